// File: rtl/riscv_pkg.sv
// riscv_pkg: opcode constants, fetch state encoding and default reset PC shared by fetch and control
package riscv_pkg;
   localparam logic [6:0] R_Type       = 7'h33;
   localparam logic [6:0] I_Type_Logic = 7'h13;
   localparam logic [6:0] U_Type       = 7'h37;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
   typedef enum logic [1:0] {FETCH, VALID, DISCARD} fetch_state_e;
endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC register, memory req/ack fetch and valid/ready hand-off to decode
module instruction_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_o,
   output logic [6:0]  op_o,
   output logic [31:0] pc_o,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i
);
   fetch_state_e state_q, state_d;
   logic [31:0] pc_q, pc_d, pend_q, pend_d, instr_q, instr_d, pco_q, pco_d, tgt;
   assign tgt           = redirect_pc_i & 32'hFFFF_FFFC;
   assign mem_req_o     = state_q != VALID;
   assign mem_addr_o    = pc_q;
   assign instr_valid_o = state_q == VALID;
   assign instr_o       = instr_q;
   assign op_o          = instr_q[6:0];
   assign pc_o          = pco_q;
   // next state: a redirect beats ack and ready; a request in flight is finished in DISCARD, never withdrawn
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      pend_d  = pend_q;
      instr_d = instr_q;
      pco_d   = pco_q;
      case (state_q)
         FETCH: begin
            if (mem_ack_i && redirect_i) pc_d = tgt;
            else if (mem_ack_i) begin
               instr_d = mem_rdata_i;
               pco_d   = pc_q;
               pc_d    = pc_q + 32'd4;
               state_d = VALID;
            end else if (redirect_i) begin
               pend_d  = tgt;
               state_d = DISCARD;
            end
         end
         DISCARD: begin
            if (mem_ack_i) begin
               pc_d    = redirect_i ? tgt : pend_q;
               state_d = FETCH;
            end else if (redirect_i) pend_d = tgt;
         end
         VALID: begin
            if (redirect_i) begin
               pc_d    = tgt;
               state_d = FETCH;
            end else if (instr_ready_i) state_d = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end
   // registers; reset abandons any in-flight memory transaction
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         pend_q  <= '0;
         instr_q <= '0;
         pco_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         instr_q <= instr_d;
         pco_q   <= pco_d;
      end
   end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: randomized fetch traffic checked by an instruction-stream scoreboard
module tb_instruction_fetch_unit;
   localparam logic [31:0] RPC = 32'h0040_0000;
   logic clk, reset;
   logic mem_req_o, mem_ack_i, instr_valid_o, instr_ready_i, redirect_i;
   logic [31:0] mem_addr_o, mem_rdata_i, instr_o, pc_o, redirect_pc_i;
   logic [6:0] op_o;
   logic w_req, w_ack, w_valid, w_ready, w_red;
   logic [31:0] w_addr, w_instr, w_pc, w_rdata, w_tgt;
   logic [6:0] w_op;
   int checks = 0, failures = 0;
   logic [31:0] exp_q[$];
   logic chk_rst = 0, chk_req = 0, chk_nv = 0, chk_v = 0, disc = 0;
   logic [31:0] exp_addr, pend;

   instruction_fetch_unit dut (
      .clk(clk), .reset(reset), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .instr_valid_o(instr_valid_o),
      .instr_ready_i(instr_ready_i), .instr_o(instr_o), .op_o(op_o), .pc_o(pc_o),
      .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i));

   assign w_ack   = w_req;
   assign w_ready = 1'b1;
   assign w_red   = 1'b0;
   assign w_rdata = 32'h0000_0013;
   assign w_tgt   = 32'h0;
   instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
      .clk(clk), .reset(reset), .mem_req_o(w_req), .mem_addr_o(w_addr),
      .mem_ack_i(w_ack), .mem_rdata_i(w_rdata), .instr_valid_o(w_valid),
      .instr_ready_i(w_ready), .instr_o(w_instr), .op_o(w_op), .pc_o(w_pc),
      .redirect_i(w_red), .redirect_pc_i(w_tgt));

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == RPC) ? 32'h0000_0033 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [31:0] align(input logic [31:0] a);
      return {a[31:2], 2'b00};
   endfunction

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   // one cycle of stimulus: ap/rp/rd are percent chances of ack, ready and redirect
   task automatic step(input int ap, input int rp, input int rd, input logic [31:0] t);
      @(posedge clk);
      #1;
      mem_ack_i     = mem_req_o && (int'($urandom_range(99)) < ap);
      mem_rdata_i   = mem_ack_i ? mem_fn(mem_addr_o) : $urandom();
      instr_ready_i = int'($urandom_range(99)) < rp;
      redirect_i    = int'($urandom_range(99)) < rd;
      redirect_pc_i = t;
      if (redirect_i) begin
         exp_q.delete();
         exp_q.push_back(align(t));
      end
   endtask

   task automatic do_reset(input int n);
      reset = 1;
      exp_q.delete();
      exp_q.push_back(RPC);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
      reset = 0;
   endtask

   task automatic wait_req();
      for (int i = 0; i < 30 && !mem_req_o; i++) step(0, 0, 0, 0);
      chk("wait_req", mem_req_o, 1);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 30 && !instr_valid_o; i++) step(100, 0, 0, 0);
      chk("wait_valid", instr_valid_o, 1);
   endtask

   // stimulus
   initial begin
      reset = 1;
      mem_ack_i = 0;
      mem_rdata_i = 0;
      instr_ready_i = 0;
      redirect_i = 0;
      redirect_pc_i = 0;
      do_reset(3);
      for (int i = 0; i < 8; i++) step(100, 100, 0, 0);
      wait_req();
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      step(100, 0, 0, 0);
      wait_valid();
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
      step(0, 100, 0, 0);
      wait_req();
      step(0, 0, 100, 32'h0040_0100);
      step(0, 0, 0, 0);
      step(100, 0, 0, 0);
      wait_valid();
      step(0, 100, 100, 32'h0040_0202);
      for (int i = 0; i < 6; i++) step(100, 100, 0, 0);
      for (int i = 0; i < 3000; i++)
         step(50, 60, 4, ($urandom_range(9) == 0) ? 32'hFFFF_FFF0 + $urandom_range(15)
                                                  : RPC + $urandom_range(4095));
      wait_req();
      do_reset(2);
      @(negedge clk);
      chk("wrap_req0", w_req, 1);
      chk("wrap_addr0", w_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_valid", w_valid, 1);
      chk("wrap_pc", w_pc, 32'hFFFF_FFFC);
      @(negedge clk);
      chk("wrap_req1", w_req, 1);
      chk("wrap_addr1", w_addr, 32'h0);
      for (int i = 0; i < 10; i++) step(100, 100, 0, 0);
      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // monitor: one view per cycle at negedge, expectations carried to the next cycle
   initial begin
      forever begin
         @(negedge clk);
         if (chk_rst) begin
            chk("rst_valid", instr_valid_o, 0);
            chk("rst_instr", instr_o, 0);
            chk("rst_pc_o", pc_o, 0);
            chk("rst_req", mem_req_o, 1);
            chk("rst_addr", mem_addr_o, RPC);
         end
         if (chk_req) begin
            chk("req_issue", mem_req_o, 1);
            chk("req_addr", mem_addr_o, exp_addr);
         end
         if (chk_nv) chk("valid_low", instr_valid_o, 0);
         if (chk_v) chk("valid_high", instr_valid_o, 1);
         chk_rst = 0;
         chk_req = 0;
         chk_nv = 0;
         chk_v = 0;
         if (reset) begin
            chk_rst = 1;
            disc = 0;
         end else begin
            chk("req_xor_valid", {31'b0, mem_req_o ^ instr_valid_o}, 1);
            if (mem_req_o) begin
               if (!mem_ack_i) begin
                  chk_req = 1;
                  exp_addr = mem_addr_o;
                  chk_nv = 1;
                  if (redirect_i) begin
                     disc = 1;
                     pend = align(redirect_pc_i);
                  end
               end else if (disc || redirect_i) begin
                  chk_req = 1;
                  exp_addr = redirect_i ? align(redirect_pc_i) : pend;
                  chk_nv = 1;
                  disc = 0;
               end else chk_v = 1;
            end else if (instr_valid_o) begin
               if (redirect_i) begin
                  chk_req = 1;
                  exp_addr = align(redirect_pc_i);
                  chk_nv = 1;
               end else if (instr_ready_i) begin
                  if (exp_q.size() == 0) chk("queue_empty", 1, 0);
                  else begin
                     logic [31:0] e, w;
                     e = exp_q.pop_front();
                     w = mem_fn(e);
                     chk("hs_pc", pc_o, e);
                     chk("hs_instr", instr_o, w);
                     chk("hs_op", {25'b0, op_o}, {25'b0, w[6:0]});
                     exp_q.push_back(e + 32'd4);
                     chk_req = 1;
                     exp_addr = e + 32'd4;
                     chk_nv = 1;
                  end
               end else chk_v = 1;
            end
         end
      end
   end
endmodule
